// File: rtl/uart_rx_fifo_if.sv
// Bundle between the UART receiver/host side and the receive FIFO.
// master drives receive strobes and host requests; slave is the FIFO.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int ERR_CNT_W  = 8
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ferror;
  logic                  rx_perror;
  logic                  rd_en;
  logic                  clr_status;
  logic [7:0]            rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   level;
  logic                  overrun;
  logic [ERR_CNT_W-1:0]  ferr_cnt;
  logic [ERR_CNT_W-1:0]  perr_cnt;
  logic                  irq;

  modport master (
    output rx_data, rx_valid, rx_ferror, rx_perror, rd_en, clr_status,
    input  rd_data, rd_valid, empty, full, level, overrun, ferr_cnt, perr_cnt, irq
  );

  modport slave (
    input  rx_data, rx_valid, rx_ferror, rx_perror, rd_en, clr_status,
    output rd_data, rd_valid, empty, full, level, overrun, ferr_cnt, perr_cnt, irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with sticky overrun and saturating frame/parity error counters.
// Optional interrupt output enabled by defining UART_RX_FIFO_IRQ_EN.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int IRQ_THRESH = 12
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   level_reg, level_next;
  logic                  empty_reg, full_reg;
  logic [7:0]            rd_data_reg;
  logic                  rd_valid_reg;
  logic                  overrun_reg, overrun_next;
  logic [ERR_CNT_W-1:0]  ferr_cnt_reg, ferr_cnt_next;
  logic [ERR_CNT_W-1:0]  perr_cnt_reg, perr_cnt_next;
  logic                  wr, rd_accept, ovf_event;

  always_comb begin
    rd_accept = bus.rd_en & ~empty_reg;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    wr        = bus.rx_valid & ~bus.rx_ferror & ~bus.rx_perror & (~full_reg | rd_accept);
    ovf_event = bus.rx_valid & full_reg & ~rd_accept;

    level_next = level_reg;
    if (wr && !rd_accept)
      level_next = level_reg + 1'b1;
    else if (!wr && rd_accept)
      level_next = level_reg - 1'b1;

    overrun_next = (overrun_reg & ~bus.clr_status) | ovf_event;

    ferr_cnt_next = ferr_cnt_reg;
    if (bus.clr_status)
      ferr_cnt_next = {{(ERR_CNT_W-1){1'b0}}, bus.rx_ferror};
    else if (bus.rx_ferror && !(&ferr_cnt_reg))
      ferr_cnt_next = ferr_cnt_reg + 1'b1;

    perr_cnt_next = perr_cnt_reg;
    if (bus.clr_status)
      perr_cnt_next = {{(ERR_CNT_W-1){1'b0}}, bus.rx_perror};
    else if (bus.rx_perror && !(&perr_cnt_reg))
      perr_cnt_next = perr_cnt_reg + 1'b1;
  end

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr_reg] <= bus.rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      empty_reg    <= 1'b1;
      full_reg     <= 1'b0;
      rd_data_reg  <= 8'h00;
      rd_valid_reg <= 1'b0;
      overrun_reg  <= 1'b0;
      ferr_cnt_reg <= '0;
      perr_cnt_reg <= '0;
    end else begin
      if (wr)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_accept) begin
        rd_data_reg <= mem[rd_ptr_reg];
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
      end
      rd_valid_reg <= rd_accept;
      level_reg    <= level_next;
      empty_reg    <= (level_next == '0);
      full_reg     <= (level_next == DEPTH_LVL);
      overrun_reg  <= overrun_next;
      ferr_cnt_reg <= ferr_cnt_next;
      perr_cnt_reg <= perr_cnt_next;
    end
  end

  assign bus.rd_data  = rd_data_reg;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.empty    = empty_reg;
  assign bus.full     = full_reg;
  assign bus.level    = level_reg;
  assign bus.overrun  = overrun_reg;
  assign bus.ferr_cnt = ferr_cnt_reg;
  assign bus.perr_cnt = perr_cnt_reg;

`ifdef UART_RX_FIFO_IRQ_EN
  logic irq_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      irq_reg <= 1'b0;
    else
      irq_reg <= (int'(level_next) >= IRQ_THRESH) | overrun_next;
  end

  assign bus.irq = irq_reg;
`else
  // Threshold kept referenced so both builds share one parameter list; folds to 0.
  assign bus.irq = 1'b0 && (IRQ_THRESH >= 0);
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: random and directed stimulus against a queue model.
module tb_uart_rx_fifo;
  localparam int DL2    = 4;
  localparam int EW     = 8;
  localparam int DEPTH  = 16;
  localparam int THRESH = 12;
  localparam int SAT    = (1 << EW) - 1;
`ifdef UART_RX_FIFO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH_LOG2(DL2), .ERR_CNT_W(EW)) bus ();

  uart_rx_fifo #(.DEPTH_LOG2(DL2), .ERR_CNT_W(EW), .IRQ_THRESH(THRESH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: byte queue plus status as observed after each clock edge.
  logic [7:0] q[$];
  logic [7:0] m_rd_data;
  bit         m_rd_valid, m_overrun, m_irq;
  int         m_ferr, m_perr;

  function automatic void model_reset();
    q.delete();
    m_rd_data  = 8'h00;
    m_rd_valid = 1'b0;
    m_overrun  = 1'b0;
    m_irq      = 1'b0;
    m_ferr     = 0;
    m_perr     = 0;
  endfunction

  function automatic logic [33:0] exp_vec();
    return {5'(q.size()), q.size() == 0, q.size() == DEPTH, m_rd_valid, m_rd_data,
            m_overrun, 8'(m_ferr), 8'(m_perr), m_irq};
  endfunction

  function automatic logic [33:0] dut_vec();
    return {bus.level, bus.empty, bus.full, bus.rd_valid, bus.rd_data,
            bus.overrun, bus.ferr_cnt, bus.perr_cnt, bus.irq};
  endfunction

  task automatic idle_inputs();
    bus.rx_valid = 0; bus.rx_data = 8'h00; bus.rx_ferror = 0;
    bus.rx_perror = 0; bus.rd_en = 0; bus.clr_status = 0;
  endtask

  // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input bit rxv, input logic [7:0] d, input bit fe, input bit pe,
                       input bit rd, input bit clr);
    bit rd_ok, wr_ok, ovf;
    bus.rx_valid = rxv; bus.rx_data = d; bus.rx_ferror = fe;
    bus.rx_perror = pe; bus.rd_en = rd; bus.clr_status = clr;
    rd_ok = rd && (q.size() > 0);
    wr_ok = rxv && !fe && !pe && ((q.size() < DEPTH) || rd_ok);
    ovf   = rxv && (q.size() == DEPTH) && !rd_ok;
    m_rd_valid = rd_ok;
    if (rd_ok) m_rd_data = q.pop_front();
    if (wr_ok) q.push_back(d);
    m_overrun = (m_overrun && !clr) || ovf;
    m_ferr = clr ? int'(fe) : (fe ? ((m_ferr < SAT) ? m_ferr + 1 : SAT) : m_ferr);
    m_perr = clr ? int'(pe) : (pe ? ((m_perr < SAT) ? m_perr + 1 : SAT) : m_perr);
    m_irq  = IRQ_EN && ((q.size() >= THRESH) || m_overrun);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && q.size() > 0; i++) cycle(0, 8'h00, 0, 0, 1, 0);
    cycle(0, 8'h00, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== {5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", dut_vec(),
               {5'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0});
    end
    reset = 1'b0;
    cycle(0, 8'h00, 0, 0, 0, 0);
    $display("test_reset done level=%0d empty=%0b", bus.level, bus.empty);
  endtask

  task automatic test_basic();
    logic [23:0] pat = 24'h55A30F;
    for (int i = 0; i < 3; i++) cycle(1, pat[23-8*i -: 8], 0, 0, 0, 0);
    checks++;
    if (bus.level !== 5'd3 || bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL basic_level got=%0d/%0b want=3/0", bus.level, bus.empty);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 8'h00, 0, 0, 1, 0);
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== pat[23-8*i -: 8]) begin
        errors++;
        $display("FAIL basic_pop%0d got=%0b/%h want=1/%h", i, bus.rd_valid, bus.rd_data, pat[23-8*i -: 8]);
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL basic_state%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
    cycle(0, 8'h00, 0, 0, 0, 0);
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.empty !== 1'b1 || bus.level !== 5'd0) begin
      errors++;
      $display("FAIL basic_end got=%0b/%0b/%0d want=0/1/0", bus.rd_valid, bus.empty, bus.level);
    end
    $display("test_basic done last rd_data=%h", bus.rd_data);
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= DEPTH; i++) begin
      cycle(1, 8'(i), 0, 0, 0, 0);
      if (i == DEPTH - 1) begin
        checks++;
        if (bus.full !== 1'b1 || bus.overrun !== 1'b0) begin
          errors++;
          $display("FAIL ovf_full got=%0b/%0b want=1/0", bus.full, bus.overrun);
        end
      end
    end
    checks++;
    if (bus.overrun !== 1'b1 || bus.level !== 5'd16) begin
      errors++;
      $display("FAIL ovf_sticky got=%0b/%0d want=1/16", bus.overrun, bus.level);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 8'h00, 0, 0, 1, 0);
      checks++;
      if (bus.rd_data !== 8'(i) || dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL ovf_pop%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
    cycle(0, 8'h00, 0, 0, 0, 1);
    checks++;
    if (bus.overrun !== 1'b0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear got=%0b/%0b want=0/1", bus.overrun, bus.empty);
    end
    $display("test_overflow done overrun=%0b", bus.overrun);
  endtask

  task automatic test_simultaneous();
    int pushed = 0;
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'($urandom), 0, 0, 0, 0);
    cycle(1, 8'($urandom), 0, 0, 1, 0);
    checks++;
    if (bus.level !== 5'd16 || bus.full !== 1'b1 || bus.overrun !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL simul_full got=%h want=%h", dut_vec(), exp_vec());
    end
    while (q.size() > 1) cycle(0, 8'h00, 0, 0, 1, 0);
    cycle(1, 8'($urandom), 0, 0, 1, 0);
    checks++;
    if (bus.level !== 5'd1 || bus.rd_valid !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL simul_one got=%h want=%h", dut_vec(), exp_vec());
    end
    for (int c = 0; c < 2000 && pushed < 40; c++) begin
      bit rxv = 1'($urandom_range(0, 1));
      bit rd  = 1'($urandom_range(0, 1));
      if (rxv) pushed++;
      cycle(rxv, 8'($urandom), 0, 0, rd, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wrap_c%0d got=%h want=%h", c, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (pushed < 40) begin
      errors++;
      $display("FAIL wrap_budget got=%0d want=40", pushed);
    end
    while (q.size() > 0) begin
      cycle(0, 8'h00, 0, 0, 1, 0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wrap_drain got=%h want=%h", dut_vec(), exp_vec());
      end
    end
    cycle(0, 8'h00, 0, 0, 0, 1);
    $display("test_simultaneous done pushed=%0d", pushed);
  endtask

  task automatic test_errors();
    for (int i = 0; i < 260; i++) cycle(0, 8'h00, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 1, 0, 0);
    checks++;
    if (bus.ferr_cnt !== 8'hFF || bus.perr_cnt !== 8'd3 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL err_sat got=%h/%h want=ff/03", bus.ferr_cnt, bus.perr_cnt);
    end
    cycle(0, 8'h00, 0, 1, 0, 1);
    checks++;
    if (bus.perr_cnt !== 8'd1 || bus.ferr_cnt !== 8'd0) begin
      errors++;
      $display("FAIL err_clr got=%h/%h want=01/00", bus.perr_cnt, bus.ferr_cnt);
    end
    cycle(1, 8'h77, 1, 0, 0, 0);
    checks++;
    if (bus.level !== 5'd0 || bus.ferr_cnt !== 8'd1 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL err_suppress got=%h want=%h", dut_vec(), exp_vec());
    end
    cycle(0, 8'h00, 0, 0, 0, 1);
    $display("test_errors done ferr=%h perr=%h", bus.ferr_cnt, bus.perr_cnt);
  endtask

  task automatic test_empty_read_and_reset();
    cycle(1, 8'hA5, 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 1, 0);
    cycle(0, 8'h00, 0, 0, 1, 0);
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'hA5 || bus.level !== 5'd0) begin
      errors++;
      $display("FAIL empty_read got=%0b/%h/%0d want=0/a5/0", bus.rd_valid, bus.rd_data, bus.level);
    end
    for (int i = 0; i < 5; i++) cycle(1, 8'($urandom), 0, 0, 0, 0);
    checks++;
    if (bus.level !== 5'd5 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL pre_reset got=%h want=%h", dut_vec(), exp_vec());
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.rd_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got=%0d/%0b/%h want=0/1/00", bus.level, bus.empty, bus.rd_data);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(0, 8'h00, 0, 0, 0, 0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL post_reset got=%h want=%h", dut_vec(), exp_vec());
    end
    $display("test_empty_read_and_reset done level=%0d", bus.level);
  endtask

  task automatic test_irq();
    for (int i = 0; i < THRESH - 1; i++) cycle(1, 8'($urandom), 0, 0, 0, 0);
    checks++;
    if (bus.irq !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL irq_below got=%0b want=0", bus.irq);
    end
    cycle(1, 8'($urandom), 0, 0, 0, 0);
    checks++;
    if (bus.irq !== IRQ_EN || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL irq_at got=%0b want=%0b", bus.irq, IRQ_EN);
    end
    cycle(0, 8'h00, 0, 0, 1, 0);
    checks++;
    if (bus.irq !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL irq_pop got=%0b want=0", bus.irq);
    end
    drain();
    $display("test_irq done irq=%0b", bus.irq);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_simultaneous();
    test_errors();
    test_empty_read_and_reset();
    test_irq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver. Captures each received byte on the receiver's one-cycle valid strobe into a circular FIFO.
- Presents the bytes to the host through a registered pop interface.
- Maintains sticky overrun status and saturating frame and parity error counters, so bytes are not lost between host polls.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (default depth 16 entries)
- ERR_CNT_W, 8, width of each error counter
- IRQ_THRESH, 12, fill level at or above which irq asserts (used only with the optional feature)

Ports:
- clk  in  1  system clock, same domain as the receiver
- reset  in  1  asynchronous, active-high
- rx_data  in  8  received byte; sampled only in a cycle with rx_valid=1
- rx_valid  in  1  one-cycle strobe: rx_data is a good byte
- rx_ferror  in  1  one-cycle framing-error strobe (start bit or stop bit)
- rx_perror  in  1  one-cycle parity-error strobe
- rd_en  in  1  host pop request
- clr_status  in  1  one-cycle clear of overrun flag and error counters
- rd_data  out  8  popped byte, registered
- rd_valid  out  1  one-cycle pulse: rd_data was updated this cycle
- empty  out  1  level==0
- full  out  1  level==2**DEPTH_LOG2
- level  out  DEPTH_LOG2+1  current number of stored bytes
- overrun  out  1  sticky: a byte was dropped because the FIFO was full
- ferr_cnt  out  ERR_CNT_W  saturating framing-error count
- perr_cnt  out  ERR_CNT_W  saturating parity-error count
- irq  out  1  interrupt (optional feature; otherwise tied 0)

Behaviour:
- Reset (async): write pointer, read pointer and level = 0; empty=1; full=0; rd_data=8'h00; rd_valid=0; overrun=0; ferr_cnt=0; perr_cnt=0; irq=0. Storage contents are don't-care.
- Pointers: DEPTH_LOG2 bits wide, wrap modulo depth. level is tracked as an explicit counter. empty, full and level are registered and consistent with the pointers in every cycle.
- Write acceptance:
  - wr = rx_valid & ~rx_ferror & ~rx_perror & (~full | rd_accept).
  - An error strobe coincident with rx_valid suppresses the write (defensive).
- Read acceptance:
  - rd_accept = rd_en & ~empty.
  - On the next edge: rd_data <= mem[rd_ptr], rd_ptr++, and rd_valid=1 for exactly that one cycle.
  - rd_en while empty is ignored: rd_data holds, rd_valid=0, no status change. There is no write-to-read bypass.
- Level update:
  - wr only: +1.
  - rd_accept only: -1.
  - Both in the same cycle: unchanged.
  - Full + rd_accept + rx_valid: both complete, level stays at depth, no overrun.
- Overrun: rx_valid & full & ~rd_accept drops the byte and sets overrun=1 on the next edge. FIFO contents are untouched.
- Error counters:
  - Each rx_ferror pulse increments ferr_cnt; each rx_perror pulse increments perr_cnt.
  - Both counters saturate at all-ones.
  - Start-bit framing errors (no rx_valid) are counted.
- clr_status:
  - Sets overrun=0 and both counters to 0 on the next edge.
  - An error/overrun event in the same cycle as clr_status is still recorded: the counter becomes 1, or overrun becomes 1.
  - clr_status does not affect FIFO data, pointers or level.
- Latency: a byte strobed at edge N is visible in level/empty at edge N+1. The earliest pop is requested in cycle N+1, and rd_valid is seen at N+2.
- Reset mid-operation: all stored bytes are discarded and outputs return to their reset values immediately.

Optional Feature:
- Macro UART_RX_FIFO_IRQ_EN.
- Defined: irq is a registered level = (level_next >= IRQ_THRESH) | overrun_next. It deasserts when the level drops below IRQ_THRESH and overrun is cleared.
- Undefined: irq is constant 0, the comparator is not built, and IRQ_THRESH is unused. The port list is identical in both builds.

Test Plan:
- Push 0x55, 0xA3, 0x0F via rx_valid strobes, then rd_en x3 -> rd_data 0x55, 0xA3, 0x0F, each with a one-cycle rd_valid; level 3->0; empty=1 at end.
- Push 17 bytes 0x00..0x10 with no reads -> full=1 after the 16th; overrun=1 after the 17th; popping 16 bytes yields 0x00..0x0F (0x10 lost); clr_status -> overrun=0.
- Pop and strobe in the same cycle at full, and separately at level=1 -> no overrun; level unchanged; FIFO order preserved across pointer wrap (push/pop 40 bytes).
- 260 rx_ferror pulses plus 3 rx_perror pulses -> ferr_cnt=0xFF (saturated), perr_cnt=3; clr_status coincident with one rx_perror -> perr_cnt=1, ferr_cnt=0.
- rd_en at empty -> rd_valid=0, rd_data holds previous value; assert reset with 5 bytes stored -> level=0, empty=1, rd_data=0x00 without waiting for a clock edge.
- With UART_RX_FIFO_IRQ_EN: push 11 bytes -> irq=0; 12th -> irq=1; one pop -> irq=0. Without the macro: irq=0 throughout.
